// File: rtl/uart_msg_pkg.sv
// Shared types, constants and byte helpers for the UART message sequencer.
`timescale 1ns/1ps
package uart_msg_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StSend = 2'd2,
        StWait = 2'd3
    } state_e;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam int unsigned MSG_LEN = 4;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        // 0x37 + n maps 10..15 onto 'A'..'F'
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [7:0] frame_byte(input logic [1:0] idx, input logic [7:0] data);
        logic [7:0] b;
        case (idx)
            2'd0:    b = hex_ascii(data[7:4]);
            2'd1:    b = hex_ascii(data[3:0]);
            2'd2:    b = ASCII_CR;
            default: b = ASCII_LF;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_msg_sequencer_edge_detect.sv
// Rising-edge one-shot: high for the single cycle where d_i=1 and the previous sample was 0.
`timescale 1ns/1ps
module edge_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o
);

    logic d_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d_i;
        end
    end

    assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/uart_msg_sequencer.sv
// Button-triggered sender of "HH\r\n" frames through a send/busy UART transmitter.
// Optional auto-repeat while the button is held: define UART_MSG_AUTO_REPEAT_EN.
`timescale 1ns/1ps
module uart_msg_sequencer
    import uart_msg_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT   = 1000
`ifdef UART_MSG_AUTO_REPEAT_EN
    ,
    parameter int unsigned REPEAT_CYCLES = 50_000_000
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn,
    input  logic [7:0] sw,
    input  logic       tx_busy,
    output logic       tx_send,
    output logic [7:0] tx_din,
    output logic       active,
    output logic       err
);

    state_e      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  tx_din_q, tx_din_d;
    logic        tx_send_q, tx_send_d;
    logic        active_q, active_d;
    logic        err_q, err_d;
    logic [15:0] cnt_q, cnt_d;
    logic        trig;
    logic        start;

    edge_detect u_edge_detect (
        .clk_i  (clk),
        .rst_ni (reset),
        .d_i    (btn),
        .rise_o (trig)
    );

`ifdef UART_MSG_AUTO_REPEAT_EN
    localparam logic [25:0] RepeatMax = 26'(REPEAT_CYCLES);

    logic [25:0] hold_q, hold_d;

    // Saturates at RepeatMax so a long frame still repeats once it is back in idle.
    always_comb begin
        hold_d = hold_q;
        if (!btn) begin
            hold_d = '0;
        end else if (state_q == StIdle && start) begin
            hold_d = '0;
        end else if (hold_q != RepeatMax) begin
            hold_d = hold_q + 26'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    assign start = trig | (btn & (hold_q == RepeatMax));
`else
    assign start = trig;
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        data_d    = data_q;
        tx_din_d  = tx_din_q;
        tx_send_d = tx_send_q;
        active_d  = active_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        case (state_q)
            StIdle: begin
                tx_send_d = 1'b0;
                cnt_d     = '0;
                if (start) begin
                    data_d   = sw;
                    idx_d    = 2'd0;
                    err_d    = 1'b0;
                    active_d = 1'b1;
                    state_d  = StLoad;
                end
            end
            StLoad: begin
                tx_din_d  = frame_byte(idx_q, data_q);
                tx_send_d = 1'b1;
                cnt_d     = '0;
                state_d   = StSend;
            end
            StSend: begin
                if (tx_busy) begin
                    tx_send_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = StWait;
                end else if (cnt_q == 16'(ACK_TIMEOUT - 1)) begin
                    tx_send_d = 1'b0;
                    err_d     = 1'b1;
                    active_d  = 1'b0;
                    cnt_d     = '0;
                    state_d   = StIdle;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StWait: begin
                tx_send_d = 1'b0;
                if (!tx_busy) begin
                    if (idx_q == 2'(MSG_LEN - 1)) begin
                        active_d = 1'b0;
                        state_d  = StIdle;
                    end else begin
                        idx_d     = idx_q + 2'd1;
                        tx_din_d  = frame_byte(idx_q + 2'd1, data_q);
                        tx_send_d = 1'b1;
                        state_d   = StSend;
                    end
                end
            end
            default: begin
                tx_send_d = 1'b0;
                active_d  = 1'b0;
                cnt_d     = '0;
                state_d   = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            idx_q     <= 2'd0;
            data_q    <= 8'h00;
            tx_din_q  <= 8'h00;
            tx_send_q <= 1'b0;
            active_q  <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            tx_din_q  <= tx_din_d;
            tx_send_q <= tx_send_d;
            active_q  <= active_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign tx_send = tx_send_q;
    assign tx_din  = tx_din_q;
    assign active  = active_q;
    assign err     = err_q;

endmodule

// File: tb/tb_uart_msg_sequencer.sv
// Scoreboard bench for uart_msg_sequencer with a simple send/busy transmitter model.
`timescale 1ns/1ps
module tb_uart_msg_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn = 1'b0;
    logic [7:0] sw = 8'h00;
    logic       tx_busy = 1'b0;
    logic       tx_send;
    logic [7:0] tx_din;
    logic       active;
    logic       err;

    int         checks = 0;
    int         errors = 0;
    int         send_count = 0;
    int         busy_len = 10;
    bit         tx_stuck = 1'b0;
    logic       send_prev = 1'b0;
    logic [7:0] mon_exp;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_msg_sequencer #(
        .ACK_TIMEOUT   (8)
`ifdef UART_MSG_AUTO_REPEAT_EN
        ,
        .REPEAT_CYCLES (100)
`endif
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .btn     (btn),
        .sw      (sw),
        .tx_busy (tx_busy),
        .tx_send (tx_send),
        .tx_din  (tx_din),
        .active  (active),
        .err     (err)
    );

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic push_frame(input logic [7:0] b0, input logic [7:0] b1);
        exp_q.push_back(b0);
        exp_q.push_back(b1);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic press();
        @(posedge clk);
        #1 btn = 1'b0;
        @(posedge clk);
        #1 btn = 1'b1;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (active && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(active), 0);
    endtask

    // Transmitter: busy rises one cycle after it sees send, stays up busy_len cycles.
    initial begin
        forever begin
            @(posedge clk);
            if (tx_send && !tx_busy && !tx_stuck) begin
                #1 tx_busy = 1'b1;
                repeat (busy_len) @(posedge clk);
                #1 tx_busy = 1'b0;
            end
        end
    end

    // Monitor: each new send request is one byte of the frame.
    always @(negedge clk) begin
        if (tx_send && !send_prev) begin
            send_count++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_send: got tx_din=0x%02h required no send", tx_din);
            end else begin
                mon_exp = exp_q.pop_front();
                check("tx_din", int'(tx_din), int'(mon_exp));
            end
        end
        send_prev = tx_send;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int hi;
        int n;
        int base;
        int frames;

        // Reset held with the button toggling
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            btn = ~btn;
            check("reset_quiet", int'({tx_send, active, err}), 0);
        end
        btn = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (10) @(negedge clk);
        check("no_send_after_reset", send_count, 0);
        check("idle_after_reset", int'(active), 0);

        // sw=0x3C -> "3C\r\n", latency check
        sw = 8'h3C;
        push_frame(8'h33, 8'h43);
        press();
        lat = 0;
        while (!tx_send && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("first_send_latency", lat, 2);
        wait_idle(300, "frame1_done");
        btn = 1'b0;
        check("sends_frame1", send_count, 4);
        check("busy_low_at_end", int'(tx_busy), 0);
        check("err_frame1", int'(err), 0);

        // sw changes mid-frame must not affect bytes
        sw = 8'hA5;
        push_frame(8'h41, 8'h35);
        press();
        repeat (3) @(posedge clk);
        #1 sw = 8'hFF;
        wait_idle(300, "frame2_done");
        btn = 1'b0;
        check("sends_frame2", send_count, 8);

        // Second edge during byte 2 is dropped
        sw = 8'h12;
        push_frame(8'h31, 8'h32);
        press();
        n = 0;
        while (send_count < 10 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reached_byte2", int'(send_count >= 10), 1);
        @(posedge clk);
        #1 btn = 1'b0;
        @(posedge clk);
        #1 btn = 1'b1;
        wait_idle(300, "frame3_done");
        btn = 1'b0;
        repeat (30) @(negedge clk);
        check("sends_frame3", send_count, 12);

        // Acknowledge timeout
        tx_stuck = 1'b1;
        sw = 8'h7E;
        exp_q.push_back(8'h37);
        press();
        hi = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx_send) hi++;
        end
        check("timeout_send_cycles", hi, 8);
        check("timeout_err", int'(err), 1);
        check("timeout_active", int'(active), 0);
        check("timeout_sends", send_count, 13);
        tx_stuck = 1'b0;
        sw = 8'h00;
        push_frame(8'h30, 8'h30);
        press();
        repeat (2) @(negedge clk);
        check("err_cleared_by_trigger", int'(err), 0);
        check("active_after_trigger", int'(active), 1);
        wait_idle(300, "frame4_done");
        btn = 1'b0;
        check("sends_frame4", send_count, 17);

        // Held button: auto-repeat only when the feature is built in
`ifdef UART_MSG_AUTO_REPEAT_EN
        frames = 4;
`else
        frames = 1;
`endif
        busy_len = 2;
        sw = 8'h5A;
        for (int f = 0; f < frames; f++) push_frame(8'h35, 8'h41);
        base = send_count;
        press();
        repeat (350) @(posedge clk);
        #1 btn = 1'b0;
        wait_idle(300, "hold_done");
        repeat (10) @(negedge clk);
        check("hold_sends", send_count - base, 4 * frames);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_msg_sequencer.md
Name: uart_msg_sequencer

Overview:
Sequences the UART transmitter from a debounced push-button. On each debounced rising edge it samples an 8-bit switch value and transmits it as a 4-byte frame: two uppercase ASCII hex characters, then CR (0x0D) and LF (0x0A). It sits between the debounce output and the UART transmitter's send/busy interface, and owns all handshaking with the transmitter.

Parameters:
ACK_TIMEOUT, 1000, max cycles to wait for tx_busy to rise after tx_send is asserted; 16-bit counter.
REPEAT_CYCLES, 50_000_000, hold time before auto-repeat; used only with UART_MSG_AUTO_REPEAT_EN; 26-bit counter.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset; 0 = reset asserted
btn  input  1  debounced button level
sw  input  8  value to transmit
tx_busy  input  1  transmitter busy, high while a byte is in flight
tx_send  output  1  request to transmitter; held until tx_busy is seen high
tx_din  output  8  byte to transmit; stable whenever tx_send=1
active  output  1  high from trigger until the frame completes or aborts
err  output  1  sticky timeout flag; cleared by reset or the next trigger

Behaviour:
- Reset (reset=0, asynchronous) forces: state IDLE, tx_send=0, tx_din=0x00, active=0, err=0, byte index=0, btn_q=0, timeout counter=0.
- Trigger: btn=1 and btn_q=0, where btn_q is btn registered in the previous cycle. The trigger is honoured only in IDLE. A trigger in any other state is dropped, not queued.
- On trigger: latch sw into data_q, set index=0, clear err, set active=1, go to SEND next cycle.
- Frame bytes by index:
  - 0: hex(data_q[7:4])
  - 1: hex(data_q[3:0])
  - 2: 0x0D
  - 3: 0x0A
- hex(n): n<10 gives 0x30+n; n>=10 gives 0x41+n-10.
- tx_din is registered and updated on entry to SEND.
- SEND: tx_send=1 and the timeout counter increments.
  - tx_busy=1: go to WAIT, drop tx_send next cycle, clear the counter.
  - Counter reaches ACK_TIMEOUT-1 with tx_busy=0: go to IDLE, set err=1, active=0, tx_send=0.
- WAIT: tx_send=0. When tx_busy=0:
  - index=3: go to IDLE, active=0.
  - otherwise: index++ and go to SEND.
- tx_busy already high on entering SEND (transmitter still finishing a prior byte) counts as the acknowledge. Integration guarantees the transmitter deasserts busy between bytes, so WAIT is always entered at most once per byte.
- Latency: trigger edge to first tx_send=1 is 2 cycles.
- Switch changes after the trigger do not affect the frame in flight.
- The four states IDLE, LOAD, SEND, WAIT are a 2-bit enum. Illegal state encoding recovers to IDLE.

Optional Feature:
UART_MSG_AUTO_REPEAT_EN
- Defined: while btn stays 1, a hold counter runs from the trigger cycle. On return to IDLE, if the counter has reached REPEAT_CYCLES, an internal trigger starts a new frame with sw re-sampled, and the counter restarts. btn=0 clears the counter.
- Undefined: only rising edges trigger; the hold counter is not present.

Decomposition:
- Package uart_msg_pkg contains: state enum typedef, CR/LF constants, MSG_LEN=4, and the hex-to-ASCII function.
- One sub-module, edge_detect (rising-edge one-shot with async active-low reset), produces the trigger.

Test Plan:
- Reset held low with btn toggling -> tx_send=0, active=0, err=0 throughout. After release, no frame is sent until a new rising edge.
- sw=0x3C, btn rises; a transmitter model raises busy 1 cycle after send and holds it 10 cycles -> tx_din sequence 0x33, 0x43, 0x0D, 0x0A; first tx_send 2 cycles after the edge; active falls after the 4th busy falls.
- sw=0xA5 then sw changed to 0xFF mid-frame -> bytes 0x41, 0x35, 0x0D, 0x0A.
- Second btn edge during byte 2 of a frame -> no extra bytes; exactly 4 sends total.
- tx_busy stuck at 0, ACK_TIMEOUT=8 -> tx_send high exactly 8 cycles, then err=1, active=0. The next trigger clears err.
- With UART_MSG_AUTO_REPEAT_EN and REPEAT_CYCLES=100, btn held 350 cycles with a fast transmitter model -> 4 frames. Without the macro -> 1 frame.
